// File: rtl/branch_comparator_if.sv
// Handshake and result bundle for branch_comparator.
// master = producer/consumer side (pipeline), slave = the comparator itself.
interface branch_comparator_if #(
    parameter int WIDTH   = 16,
    parameter int COUNT_W = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   r0;
    logic [WIDTH-1:0]   op1;
    logic [2:0]         ctrl;
    logic               signed_cmp;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic               pcsrc;
    logic               out_eq;
    logic               out_lt;
    logic [COUNT_W-1:0] taken_cnt;
    logic [COUNT_W-1:0] total_cnt;

    modport master (
        output in_valid, r0, op1, ctrl, signed_cmp, flush, out_ready,
        input  in_ready, out_valid, pcsrc, out_eq, out_lt, taken_cnt, total_cnt
    );

    modport slave (
        input  in_valid, r0, op1, ctrl, signed_cmp, flush, out_ready,
        output in_ready, out_valid, pcsrc, out_eq, out_lt, taken_cnt, total_cnt
    );
endinterface

// File: rtl/branch_comparator.sv
// Registered branch comparator: compares r0 against op1 under a 3-bit
// condition code (signed or unsigned), holds the result in a one-deep
// output register with valid/ready backpressure and a pipeline flush.
// Optional saturating retire statistics: define BRANCH_COMPARATOR_STATS_EN
// to build taken_cnt/total_cnt; otherwise both outputs are tied to 0.
//
// state | meaning
// ------+------------------------------------------
// EMPTY | no result held, out_valid=0
// FULL  | result held in output register, out_valid=1
module branch_comparator #(
    parameter int WIDTH   = 16,
    parameter int COUNT_W = 16
) (
    input logic                clk,
    input logic                rst,
    branch_comparator_if.slave bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [2:0] CC_EQ     = 3'b000;
    localparam logic [2:0] CC_NE     = 3'b001;
    localparam logic [2:0] CC_LT     = 3'b010;
    localparam logic [2:0] CC_GT     = 3'b011;
    localparam logic [2:0] CC_LE     = 3'b100;
    localparam logic [2:0] CC_GE     = 3'b101;
    localparam logic [2:0] CC_ALWAYS = 3'b110;
    localparam logic [2:0] CC_NEVER  = 3'b111;

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] r0_w;
    logic [WIDTH-1:0] op1_w;
    logic             cmp_eq;
    logic             cmp_lt;
    logic             cmp_taken;

    logic             out_valid_w;
    logic             in_ready_w;
    logic             accept;
    logic             retire;
    logic             load;

    logic             pcsrc_q;
    logic             eq_q;
    logic             lt_q;

    assign r0_w  = bus.r0;
    assign op1_w = bus.op1;

    // Full-width equality and ordering in the selected number system.
    always_comb begin
        cmp_eq = (r0_w == op1_w);
        cmp_lt = 1'b0;
        if (bus.signed_cmp) begin
            cmp_lt = ($signed(r0_w) < $signed(op1_w));
        end else begin
            cmp_lt = (r0_w < op1_w);
        end
    end

    // Condition-code decode; GT/LE/GE are derived from the EQ/LT pair.
    always_comb begin
        cmp_taken = 1'b0;
        case (bus.ctrl)
            CC_EQ:     cmp_taken = cmp_eq;
            CC_NE:     cmp_taken = !cmp_eq;
            CC_LT:     cmp_taken = cmp_lt;
            CC_GT:     cmp_taken = !cmp_lt && !cmp_eq;
            CC_LE:     cmp_taken = cmp_lt || cmp_eq;
            CC_GE:     cmp_taken = !cmp_lt;
            CC_ALWAYS: cmp_taken = 1'b1;
            CC_NEVER:  cmp_taken = 1'b0;
            default:   cmp_taken = 1'b0;
        endcase
    end

    // Flush blocks acceptance outright, so a same-cycle input is never taken.
    // A flushed held result is discarded, not retired, so it is never counted.
    assign out_valid_w = (state_q == FULL);
    assign in_ready_w  = !bus.flush && (!out_valid_w || bus.out_ready);
    assign accept      = bus.in_valid && in_ready_w;
    assign retire      = out_valid_w && bus.out_ready && !bus.flush;

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and result-load decision.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                    load    = 1'b1;
                end
            end
            FULL: begin
                if (bus.flush) begin
                    state_d = EMPTY;
                end else if (retire && accept) begin
                    state_d = FULL;
                    load    = 1'b1;
                end else if (retire) begin
                    state_d = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Result register: loads on accept, otherwise holds (also while empty).
    always_ff @(posedge clk) begin
        if (rst) begin
            pcsrc_q <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else if (load) begin
            pcsrc_q <= cmp_taken;
            eq_q    <= cmp_eq;
            lt_q    <= cmp_lt;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.pcsrc     = pcsrc_q;
    assign bus.out_eq    = eq_q;
    assign bus.out_lt    = lt_q;

`ifdef BRANCH_COMPARATOR_STATS_EN
    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

    logic [COUNT_W-1:0] taken_q;
    logic [COUNT_W-1:0] total_q;

    // Saturating retire counters; each one stops independently at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_q <= '0;
            total_q <= '0;
        end else if (retire) begin
            if (total_q != CNT_MAX) begin
                total_q <= total_q + 1'b1;
            end
            if (pcsrc_q && (taken_q != CNT_MAX)) begin
                taken_q <= taken_q + 1'b1;
            end
        end
    end

    assign bus.taken_cnt = taken_q;
    assign bus.total_cnt = total_q;
`else
    assign bus.taken_cnt = {COUNT_W{1'b0}};
    assign bus.total_cnt = {COUNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_branch_comparator.sv
// Directed bench for branch_comparator (WIDTH=16, COUNT_W=4).
// Counter expectations follow BRANCH_COMPARATOR_STATS_EN.
module tb_branch_comparator;

    localparam int WIDTH   = 16;
    localparam int COUNT_W = 4;
    localparam int CNT_MAX = 15;

    logic clk;
    logic rst;

    int n_cmp;
    int n_err;
    int exp_total;
    int exp_taken;

    branch_comparator_if #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) bus ();

    branch_comparator #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model of a retire: saturating counts.
    task automatic model_retire(input logic taken);
        if (exp_total < CNT_MAX) exp_total++;
        if (taken && exp_taken < CNT_MAX) exp_taken++;
    endtask

    task automatic check_cnt(input string tag);
`ifdef BRANCH_COMPARATOR_STATS_EN
        check_val({tag, "_total"}, 32'(bus.total_cnt), 32'(exp_total));
        check_val({tag, "_taken"}, 32'(bus.taken_cnt), 32'(exp_taken));
`else
        check_val({tag, "_total"}, 32'(bus.total_cnt), 32'd0);
        check_val({tag, "_taken"}, 32'(bus.taken_cnt), 32'd0);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_total = 0;
        exp_taken = 0;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [2:0] cc, input logic sgn);
        bus.r0         = a;
        bus.op1        = b;
        bus.ctrl       = cc;
        bus.signed_cmp = sgn;
    endtask

    // Accept one vector, check the registered result, then retire it.
    task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [2:0] cc, input logic sgn,
                           input logic e_pc, input logic e_eq, input logic e_lt);
        drive(a, b, cc, sgn);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check_val({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check_val({tag, "_pcsrc"}, 32'(bus.pcsrc), 32'(e_pc));
        check_val({tag, "_eq"}, 32'(bus.out_eq), 32'(e_eq));
        check_val({tag, "_lt"}, 32'(bus.out_lt), 32'(e_lt));
        tick();
        model_retire(e_pc);
    endtask

    logic [7:0] sweep_lt;
    logic [7:0] sweep_eq;

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_total = 0;
        exp_taken = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        drive(16'h0, 16'h0, 3'b000, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        #1;
        check_val("rst_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_pcsrc", 32'(bus.pcsrc), 32'd0);
        check_val("rst_eq", 32'(bus.out_eq), 32'd0);
        check_val("rst_lt", 32'(bus.out_lt), 32'd0);
        check_val("rst_ready", 32'(bus.in_ready), 32'd1);
        check_cnt("rst");

        // Signed vs unsigned
        run_one("gt_u", 16'hFFF0, 16'hFF00, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0);
        run_one("gt_s", 16'hFFF0, 16'hFF00, 3'b011, 1'b1, 1'b1, 1'b0, 1'b0);
        run_one("lt_u", 16'hFFF0, 16'hFF00, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        run_one("lt_s", 16'hFFF0, 16'hFF00, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
        run_one("neg_s", 16'h8000, 16'h0001, 3'b010, 1'b1, 1'b1, 1'b0, 1'b1);
        run_one("neg_u", 16'h8000, 16'h0001, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        run_one("ge_s", 16'h8000, 16'h0001, 3'b101, 1'b1, 1'b0, 1'b0, 1'b1);
        check_cnt("sgn");

        // All codes, r0 < op1: 0,1,1,0,1,0,1,0 (bit i = code i)
        sweep_lt = 8'b0101_0110;
        for (int i = 0; i < 8; i++) begin
            run_one($sformatf("swlt%0d", i), 16'h4545, 16'h4546, 3'(i), 1'b0,
                    sweep_lt[i], 1'b0, 1'b1);
        end
        // All codes, r0 == op1: 1,0,0,0,1,1,1,0
        sweep_eq = 8'b0111_0001;
        for (int i = 0; i < 8; i++) begin
            run_one($sformatf("sweq%0d", i), 16'hFF0F, 16'hFF0F, 3'(i), 1'b1,
                    sweep_eq[i], 1'b1, 1'b0);
        end
        check_cnt("sweep");

        // Backpressure
        do_reset();
        bus.out_ready = 1'b0;
        drive(16'hFFF0, 16'hFF00, 3'b000, 1'b0);
        bus.in_valid = 1'b1;
        tick();
        drive(16'h0005, 16'h0005, 3'b000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("bp_ready%0d", i), 32'(bus.in_ready), 32'd0);
            check_val($sformatf("bp_valid%0d", i), 32'(bus.out_valid), 32'd1);
            check_val($sformatf("bp_pcsrc%0d", i), 32'(bus.pcsrc), 32'd0);
            check_val($sformatf("bp_eq%0d", i), 32'(bus.out_eq), 32'd0);
            tick();
        end
        check_cnt("bp_stall");
        bus.out_ready = 1'b1;
        #1;
        check_val("bp_ready_up", 32'(bus.in_ready), 32'd1);
        tick();
        model_retire(1'b0);
        bus.in_valid = 1'b0;
        check_val("bp_swap_valid", 32'(bus.out_valid), 32'd1);
        check_val("bp_swap_pcsrc", 32'(bus.pcsrc), 32'd1);
        check_val("bp_swap_eq", 32'(bus.out_eq), 32'd1);
        check_cnt("bp_swap");
        tick();
        model_retire(1'b1);
        check_val("bp_drain_valid", 32'(bus.out_valid), 32'd0);
        check_val("bp_hold_pcsrc", 32'(bus.pcsrc), 32'd1);
        check_cnt("bp_drain");

        // Flush while stalled, with a same-cycle input
        bus.out_ready = 1'b0;
        drive(16'h0001, 16'h0002, 3'b001, 1'b0);
        bus.in_valid = 1'b1;
        tick();
        check_val("fl_held", 32'(bus.out_valid), 32'd1);
        drive(16'h0007, 16'h0007, 3'b000, 1'b0);
        bus.flush = 1'b1;
        #1;
        check_val("fl_ready", 32'(bus.in_ready), 32'd0);
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check_val("fl_valid", 32'(bus.out_valid), 32'd0);
        check_cnt("fl");
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val($sformatf("fl_gone%0d", i), 32'(bus.out_valid), 32'd0);
        end
        check_cnt("fl_after");

        // Flush with out_ready=1: held result discarded, not retired
        drive(16'h0003, 16'h0003, 3'b000, 1'b0);
        bus.in_valid = 1'b1;
        tick();
        bus.flush = 1'b1;
        #1;
        check_val("fl2_ready", 32'(bus.in_ready), 32'd0);
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check_val("fl2_valid", 32'(bus.out_valid), 32'd0);
        check_cnt("fl2");

        // Counter saturation: 20 ALWAYS retires
        do_reset();
        check_cnt("sat_rst");
        drive(16'h1234, 16'h4321, 3'b110, 1'b0);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i > 0) model_retire(1'b1);
        end
        bus.in_valid = 1'b0;
        tick();
        model_retire(1'b1);
        check_cnt("sat");
`ifdef BRANCH_COMPARATOR_STATS_EN
        check_val("sat_total15", 32'(bus.total_cnt), 32'd15);
`else
        check_val("sat_total0", 32'(bus.total_cnt), 32'd0);
`endif
        tick();
        tick();
        check_cnt("sat_hold");
        // Untaken retires keep total pinned, taken unaffected.
        run_one("sat_never", 16'h1, 16'h2, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1);
        check_cnt("sat_never");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_total = 0;
        exp_taken = 0;
        check_cnt("sat_clr");

        // Reset mid-operation
        bus.out_ready = 1'b0;
        drive(16'h0, 16'h0, 3'b110, 1'b0);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check_val("mid_valid_pre", 32'(bus.out_valid), 32'd1);
        check_val("mid_pcsrc_pre", 32'(bus.pcsrc), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("mid_valid", 32'(bus.out_valid), 32'd0);
        check_val("mid_pcsrc", 32'(bus.pcsrc), 32'd0);
        check_val("mid_ready", 32'(bus.in_ready), 32'd1);
        check_cnt("mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_comparator.md
Name: branch_comparator

Overview:
- Parametrised, registered successor to the combinational branch comparator in the CPU branch path.
- Compares r0 against op1 under a 3-bit condition code, with signed or unsigned mode, and produces PCSrc.
- Has valid/ready handshakes on both sides, a one-deep output register with backpressure, and a flush for pipeline redirect.
- Optional saturating branch statistics counters.

Parameters:
- WIDTH, 16, operand width in bits (>= 2)
- COUNT_W, 16, width of statistics counters (>= 1)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand/condition present
- in_ready  output  1  block can accept this cycle
- r0  input  WIDTH  first operand
- op1  input  WIDTH  second operand
- ctrl  input  3  condition code
- signed_cmp  input  1  1 = two's-complement compare, 0 = unsigned
- flush  input  1  discard held result and any same-cycle input
- out_valid  output  1  registered result valid
- out_ready  input  1  consumer takes result
- pcsrc  output  1  1 = branch taken
- out_eq  output  1  registered r0 == op1
- out_lt  output  1  registered r0 < op1 (mode per signed_cmp)
- taken_cnt  output  COUNT_W  taken branches retired
- total_cnt  output  COUNT_W  branches retired

Behaviour:
- Reset (rst=1 at clock edge): out_valid, pcsrc, out_eq, out_lt, taken_cnt and total_cnt all go to 0. Reset has priority over flush and over all handshakes.
- Condition codes:
  - 000 EQ, 001 NE, 010 LT, 011 GT
  - 100 LE, 101 GE, 110 ALWAYS (taken), 111 NEVER (not taken)
- Compare:
  - Full WIDTH bits are compared; signed_cmp selects two's-complement or unsigned ordering.
  - GT = !LT & !EQ; LE = LT | EQ; GE = !LT.
  - out_eq/out_lt are reported for every code, including ALWAYS and NEVER.
- Handshakes:
  - Accept when in_valid & in_ready.
  - in_ready = !out_valid | out_ready (combinational, pass-through). in_ready does not depend on in_valid.
  - Latency is 1 cycle: a result accepted at edge N is visible with out_valid=1 after edge N.
  - Retire when out_valid & out_ready.
  - Simultaneous retire and accept: the new result replaces the old one with no bubble; out_valid stays 1.
  - Retire without accept: out_valid goes to 0.
  - Stall (out_valid & !out_ready): pcsrc, out_eq and out_lt hold stable; in_ready=0.
  - Output fields are only meaningful while out_valid=1; they hold their last value when out_valid=0.
- Flush:
  - At the edge, out_valid goes to 0.
  - Any same-cycle accept is dropped, and flush overrides in_ready (treated as not accepted).
  - A held result discarded by flush is not counted.
  - flush does not alter the counters.
- Counters:
  - On each retire, total_cnt increments by 1, and taken_cnt also increments if pcsrc=1.
  - Both saturate at 2^COUNT_W-1 and never wrap; saturation of one does not stop the other.
- No internal FSM beyond the out_valid state:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
  - EMPTY->FULL on accept.
  - FULL->EMPTY on retire without accept, or on flush.
  - FULL->FULL on stall, or on retire with accept.

Optional Feature:
- Macro: BRANCH_COMPARATOR_STATS_EN.
- Defined: taken_cnt and total_cnt behave as above.
- Undefined: counter registers are not built; taken_cnt and total_cnt are driven constant 0. Ports remain so the instantiation is unchanged.

Test Plan:
- Signed vs unsigned (WIDTH=16), r0=16'hFFF0, op1=16'hFF00, ctrl=011 (GT):
  - signed_cmp=0 -> pcsrc=1, out_lt=0.
  - signed_cmp=1 (-16 vs -256) -> pcsrc=1.
  - ctrl=010 with either mode -> pcsrc=0.
- All codes: r0=16'h4545, op1=16'h4546, signed_cmp=0, sweep ctrl 000..111 -> pcsrc = 0,1,1,0,1,0,1,0; out_eq=0, out_lt=1 each time. Repeat with r0=op1=16'hFF0F -> pcsrc = 1,0,0,0,1,1,1,0.
- Backpressure: accept r0=16'hFFF0, op1=16'hFF00, ctrl=000, then hold out_ready=0 for 3 cycles with a new in_valid pending -> in_ready=0, outputs stable, pending input not accepted. Raise out_ready -> retire and accept on the same edge, out_valid stays 1, new result appears next cycle.
- Flush: result held (out_valid=1, out_ready=0), assert flush together with in_valid=1 -> next cycle out_valid=0, total_cnt unchanged, dropped input never appears.
- Counter saturation (macro defined, COUNT_W=4): retire 20 ctrl=110 results with out_ready=1 -> taken_cnt=total_cnt=15 and they stay 15. Assert rst -> both 0 next cycle. With the macro undefined, both read 0 throughout.
- Reset mid-operation: rst=1 while out_valid=1 and out_ready=0 -> next cycle out_valid=0, pcsrc=0, in_ready=1.
